// File: rtl/regfile_wb_queue.sv
// Writeback queue feeding the 32x32 register file: merges load and ALU results in order,
// drains one write per cycle and exposes a pending-write scoreboard with forwarding.
module regfile_wb_queue #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     mem_valid,
  output logic                     mem_ready,
  input  logic [4:0]               mem_adr,
  input  logic [31:0]              mem_data,
  input  logic                     alu_valid,
  output logic                     alu_ready,
  input  logic [4:0]               alu_adr,
  input  logic [31:0]              alu_data,
  output logic                     rf_en,
  output logic [4:0]               rf_w_adr,
  output logic [31:0]              rf_w_data,
  input  logic [4:0]               q_adr1,
  input  logic [4:0]               q_adr2,
  output logic                     busy1,
  output logic                     busy2,
  output logic [31:0]              fwd_data1,
  output logic [31:0]              fwd_data2,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef logic [AW-1:0] ptr_t;

  logic [4:0]  adr_q  [DEPTH];
  logic [31:0] data_q [DEPTH];
  ptr_t        rd_ptr_q, wr_ptr_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] free;
  logic        mem_push, alu_push, pop;
  ptr_t        alu_slot;

  // Ready looks only at registered occupancy; the load path keeps the last free slot.
  assign free      = CW'(DEPTH) - count_q;
  assign mem_ready = !rst && (free != '0);
  assign alu_ready = !rst && (free >= CW'(2));

  // Address-0 writes complete the handshake but are dropped.
  assign mem_push = mem_valid && mem_ready && (mem_adr != 5'd0);
  assign alu_push = alu_valid && alu_ready && (alu_adr != 5'd0);
  assign pop      = (count_q != '0);
  assign alu_slot = wr_ptr_q + ptr_t'(mem_push);

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_q + ptr_t'(mem_push) + ptr_t'(alu_push);
      rd_ptr_q <= rd_ptr_q + ptr_t'(pop);
      count_q  <= count_q + CW'(mem_push) + CW'(alu_push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (mem_push) begin
        adr_q[wr_ptr_q]  <= mem_adr;
        data_q[wr_ptr_q] <= mem_data;
      end
      if (alu_push) begin
        adr_q[alu_slot]  <= alu_adr;
        data_q[alu_slot] <= alu_data;
      end
    end
  end

  // Head write is suppressed while reset is held so a discarded entry never reaches the file.
  assign rf_en     = pop && !rst;
  assign rf_w_adr  = rf_en ? adr_q[rd_ptr_q]  : 5'd0;
  assign rf_w_data = rf_en ? data_q[rd_ptr_q] : 32'd0;
  assign count     = count_q;

  // Walk oldest to youngest so the last match wins.
  always_comb begin
    ptr_t idx;
    idx       = rd_ptr_q;
    busy1     = 1'b0;
    busy2     = 1'b0;
    fwd_data1 = 32'd0;
    fwd_data2 = 32'd0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      idx = rd_ptr_q + ptr_t'(k);
      if (k < 32'(count_q)) begin
        if ((q_adr1 != 5'd0) && (adr_q[idx] == q_adr1)) begin
          busy1     = 1'b1;
          fwd_data1 = data_q[idx];
        end
        if ((q_adr2 != 5'd0) && (adr_q[idx] == q_adr2)) begin
          busy2     = 1'b1;
          fwd_data2 = data_q[idx];
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Directed bench for regfile_wb_queue: stimulus pushes expected writes into a queue, a
// negedge monitor pops and compares them against the register-file write port.
module tb_regfile_wb_queue;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [4:0]  adr;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_valid = 1'b0, alu_valid = 1'b0;
  logic        mem_ready, alu_ready;
  logic [4:0]  mem_adr = '0, alu_adr = '0;
  logic [31:0] mem_data = '0, alu_data = '0;
  logic        rf_en;
  logic [4:0]  rf_w_adr;
  logic [31:0] rf_w_data;
  logic [4:0]  q_adr1 = '0, q_adr2 = '0;
  logic        busy1, busy2;
  logic [31:0] fwd_data1, fwd_data2;
  logic [2:0]  count;

  wr_t sbq[$];
  int  total = 0;
  int  bad = 0;
  int  mcount = 0;

  always #5 clk = ~clk;

  regfile_wb_queue #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_adr   (mem_adr),
    .mem_data  (mem_data),
    .alu_valid (alu_valid),
    .alu_ready (alu_ready),
    .alu_adr   (alu_adr),
    .alu_data  (alu_data),
    .rf_en     (rf_en),
    .rf_w_adr  (rf_w_adr),
    .rf_w_data (rf_w_data),
    .q_adr1    (q_adr1),
    .q_adr2    (q_adr2),
    .busy1     (busy1),
    .busy2     (busy2),
    .fwd_data1 (fwd_data1),
    .fwd_data2 (fwd_data2),
    .count     (count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every cycle the write port must show the oldest outstanding expected entry.
  initial begin
    logic exp_en;
    wr_t  e;
    forever begin
      @(negedge clk);
      exp_en = (sbq.size() != 0) && !rst;
      chk("rf_en", rf_en, exp_en);
      if (exp_en && rf_en === 1'b1) begin
        e = sbq.pop_front();
        chk("rf_w_adr", rf_w_adr, e.adr);
        chk("rf_w_data", rf_w_data, e.data);
      end else if (rf_en !== 1'b1) begin
        chk("rf_w_adr idle", rf_w_adr, 0);
        chk("rf_w_data idle", rf_w_data, 0);
      end
    end
  end

  // One clock of stimulus; ready and occupancy are checked against a small occupancy model.
  task automatic cyc(input logic r, input logic mv, input logic [4:0] ma, input logic [31:0] md,
                     input logic av, input logic [4:0] aa, input logic [31:0] ad);
    logic em, ea;
    wr_t  e;
    rst = r; mem_valid = mv; mem_adr = ma; mem_data = md;
    alu_valid = av; alu_adr = aa; alu_data = ad;
    @(negedge clk);
    #1;
    em = !r && (DEPTH - mcount >= 1);
    ea = !r && (DEPTH - mcount >= 2);
    chk("count", count, mcount);
    chk("mem_ready", mem_ready, em);
    chk("alu_ready", alu_ready, ea);
    if (r) begin
      sbq.delete();
      mcount = 0;
    end else begin
      if (mcount != 0) mcount--;
      if (mv && em && ma != 5'd0) begin
        e.adr = ma; e.data = md; sbq.push_back(e); mcount++;
      end
      if (av && ea && aa != 5'd0) begin
        e.adr = aa; e.data = ad; sbq.push_back(e); mcount++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic qchk(input logic [4:0] a1, input logic [4:0] a2,
                      input logic b1, input logic [31:0] f1,
                      input logic b2, input logic [31:0] f2);
    q_adr1 = a1; q_adr2 = a2;
    #1;
    chk("busy1", busy1, b1);
    chk("fwd_data1", fwd_data1, f1);
    chk("busy2", busy2, b2);
    chk("fwd_data2", fwd_data2, f2);
  endtask

  initial begin
    // Reset
    cyc(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    cyc(1'b1, 1'b1, 5'd9, 32'h9, 1'b1, 5'd10, 32'hA);
    qchk(5'd9, 5'd10, 1'b0, 32'd0, 1'b0, 32'd0);

    // Single ALU write, one cycle latency
    cyc(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'hDEADBEEF);
    chk("t1 count", count, 1);
    qchk(5'd5, 5'd0, 1'b1, 32'hDEADBEEF, 1'b0, 32'd0);
    idle();
    chk("t1 drained", count, 0);
    idle();

    // Same-cycle collision on x3: mem older, alu younger
    cyc(1'b0, 1'b1, 5'd3, 32'h11, 1'b1, 5'd3, 32'h22);
    qchk(5'd3, 5'd0, 1'b1, 32'h22, 1'b0, 32'd0);
    idle();
    qchk(5'd3, 5'd0, 1'b1, 32'h22, 1'b0, 32'd0);
    idle();
    qchk(5'd3, 5'd0, 1'b0, 32'd0, 1'b0, 32'd0);

    // Saturate both producers: occupancy 0,2,3,3,... with wrap
    for (int i = 0; i < 8; i++)
      cyc(1'b0, 1'b1, 5'(1 + i), 32'h100 + i, 1'b1, 5'(16 + i), 32'h200 + i);
    chk("t3 count", count, 3);
    for (int i = 0; i < 4; i++) idle();

    // Address-0 ALU write is accepted and dropped
    cyc(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFFFFFFFF);
    qchk(5'd0, 5'd0, 1'b0, 32'd0, 1'b0, 32'd0);
    chk("t4 count", count, 0);
    idle();

    // Reset with three entries queued
    cyc(1'b0, 1'b1, 5'd1, 32'hA1, 1'b1, 5'd2, 32'hA2);
    cyc(1'b0, 1'b1, 5'd4, 32'hA4, 1'b1, 5'd6, 32'hA6);
    chk("t5 count", count, 3);
    qchk(5'd4, 5'd6, 1'b1, 32'hA4, 1'b1, 32'hA6);
    cyc(1'b1, 1'b1, 5'd9, 32'hB9, 1'b1, 5'd10, 32'hBA);
    qchk(5'd4, 5'd6, 1'b0, 32'd0, 1'b0, 32'd0);
    chk("t5 count after rst", count, 0);
    idle();
    idle();

    // Youngest-value forwarding for x7 behind a prefill
    cyc(1'b0, 1'b1, 5'd20, 32'hC0, 1'b1, 5'd21, 32'hC1);
    cyc(1'b0, 1'b1, 5'd7, 32'd1, 1'b0, 5'd0, 32'd0);
    qchk(5'd21, 5'd7, 1'b1, 32'hC1, 1'b1, 32'd1);
    cyc(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'd2);
    qchk(5'd21, 5'd7, 1'b0, 32'd0, 1'b1, 32'd2);
    idle();
    qchk(5'd21, 5'd7, 1'b0, 32'd0, 1'b1, 32'd2);
    idle();
    qchk(5'd21, 5'd7, 1'b0, 32'd0, 1'b0, 32'd0);
    idle();
    idle();

    chk("all writes seen", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
